datamover_tcdm_ldst_arbiter: RTL and testbench

// - Successor to the static load/store mixer: merges NB_LD load channels and one store channel onto a single TCDM initiator port.
// - Tracks every issued transaction in an in-order tag FIFO, so each response returns to the load channel that requested it.
// - Store responses are dropped inside the block; no separate r_valid filter is needed.
// - Sits between the datamover sources/sink and the optional TCDM FIFO.

---
 rtl/datamover_tcdm_ldst_arbiter.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_datamover_tcdm_ldst_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamover_tcdm_ldst_arbiter.sv
// rtl/datamover_tcdm_ldst_arbiter.sv - load/store merge onto one TCDM port with in-order response tags
//
// Purpose:
//   Merges NB_LD load channels (round-robin among themselves) and one store
//   channel (alternating with the load group on contention) onto a single
//   TCDM initiator port. Every issued transaction is recorded in an in-order
//   tag FIFO so each response is steered back to the load channel that asked
//   for it; store responses are swallowed here.
//
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync clear of tags/flags)
//   ld_req_i/ld_gnt_o/ld_add_i/ld_be_i        load request side, one slot per channel
//   ld_r_data_o/ld_r_valid_o                   load responses (data broadcast, valid one-hot)
//   st_req_i/st_gnt_o/st_add_i/st_data_i/st_be_i  store request side
//   tcdm_*                                     TCDM initiator port (wen: 1 = read)
//   outstanding_o, idle_o, spurious_o          status
//
// Optional feature macro: DATAMOVER_LDST_ARB_PERF_EN adds perf_ld_stall_o,
// perf_st_stall_o and perf_full_o (32-bit wrapping event counters).

module datamover_tcdm_ldst_arbiter #(
    parameter int NB_LD           = 2,
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STORE_RESP      = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic [NB_LD-1:0]                  ld_req_i,
    output logic [NB_LD-1:0]                  ld_gnt_o,
    input  logic [NB_LD*AW-1:0]               ld_add_i,
    input  logic [NB_LD*(DW/8)-1:0]           ld_be_i,
    output logic [NB_LD*DW-1:0]               ld_r_data_o,
    output logic [NB_LD-1:0]                  ld_r_valid_o,
    input  logic                              st_req_i,
    output logic                              st_gnt_o,
    input  logic [AW-1:0]                     st_add_i,
    input  logic [DW-1:0]                     st_data_i,
    input  logic [DW/8-1:0]                   st_be_i,
    output logic                              tcdm_req_o,
    input  logic                              tcdm_gnt_i,
    output logic [AW-1:0]                     tcdm_add_o,
    output logic                              tcdm_wen_o,
    output logic [DW/8-1:0]                   tcdm_be_o,
    output logic [DW-1:0]                     tcdm_data_o,
    input  logic [DW-1:0]                     tcdm_r_data_i,
    input  logic                              tcdm_r_valid_i,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic                              idle_o,
    output logic                              spurious_o
`ifdef DATAMOVER_LDST_ARB_PERF_EN
    ,
    output logic [31:0]                       perf_ld_stall_o,
    output logic [31:0]                       perf_st_stall_o,
    output logic [31:0]                       perf_full_o
`endif
);

    localparam int BW = DW / 8;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int IW = (NB_LD > 1) ? $clog2(NB_LD) : 1;

    localparam logic [0:0]    TURN_LOAD  = 1'b0;
    localparam logic [0:0]    TURN_STORE = 1'b1;
    localparam logic [CW-1:0] CNT_FULL   = CW'(MAX_OUTSTANDING);

    // tag FIFO
    logic [CW-1:0] cnt;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          tag_is_load [MAX_OUTSTANDING];
    logic [IW-1:0] tag_ch      [MAX_OUTSTANDING];

    // arbitration state
    logic [IW-1:0] rr_ptr;
    logic [0:0]    grp_turn;
    logic          spurious;

    // latched request while waiting for tcdm_gnt_i
    logic          held;
    logic          held_is_load;
    logic          held_contend;
    logic [IW-1:0] held_ch;
    logic [AW-1:0] held_add;
    logic [DW-1:0] held_data;
    logic [BW-1:0] held_be;

    logic             full;
    logic [NB_LD-1:0] ld_cand;
    logic             st_cand;
    logic             any_ld;
    logic             rr_hit;
    logic [IW-1:0]    rr_idx;
    logic             arb_load;
    logic             arb_store;
    logic             arb_contend;
    logic [AW-1:0]    arb_add;
    logic [DW-1:0]    arb_data;
    logic [BW-1:0]    arb_be;

    logic             cur_valid;
    logic             cur_is_load;
    logic [IW-1:0]    cur_ch;
    logic             cur_contend;
    logic             gnt;
    logic             push;
    logic             pop;
    logic             cnt_nz;
    logic             head_is_load;
    logic [IW-1:0]    head_ch;

    // Full mask comes from the registered count only, so a response popping
    // a tag in this cycle cannot open a slot for a request in the same cycle.
    assign full    = (cnt == CNT_FULL);
    assign cnt_nz  = (cnt != '0);
    assign ld_cand = ld_req_i & {NB_LD{~full}};
    assign st_cand = st_req_i & ~(full & (STORE_RESP != 0));
    assign any_ld  = |ld_cand;

    // Round-robin: first candidate at or above the pointer, else the first
    // candidate from channel 0 (wrap-around search without modulo indexing).
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int i = 0; i < NB_LD; i++) begin
            if (!rr_hit && ld_cand[i] && (i >= int'(rr_ptr))) begin
                rr_hit = 1'b1;
                rr_idx = IW'(i);
            end
        end
        for (int i = 0; i < NB_LD; i++) begin
            if (!rr_hit && ld_cand[i]) begin
                rr_hit = 1'b1;
                rr_idx = IW'(i);
            end
        end
    end

    assign arb_contend = any_ld & st_cand;
    assign arb_load    = any_ld & (~st_cand | (grp_turn == TURN_LOAD));
    assign arb_store   = st_cand & ~arb_load;

    assign arb_add  = arb_load ? ld_add_i[int'(rr_idx)*AW +: AW] : st_add_i;
    assign arb_be   = arb_load ? ld_be_i[int'(rr_idx)*BW +: BW] : st_be_i;
    assign arb_data = arb_load ? '0 : st_data_i;

    // While an issued request waits for its grant, the latched copy drives
    // the port so the target sees a stable transaction.
    assign cur_valid   = held | arb_load | arb_store;
    assign cur_is_load = held ? held_is_load : arb_load;
    assign cur_ch      = held ? held_ch      : rr_idx;
    assign cur_contend = held ? held_contend : arb_contend;

    // Nothing is offered to the target while clearing or in reset.
    assign tcdm_req_o  = cur_valid & ~rst_i & ~clear_i;
    assign tcdm_add_o  = held ? held_add  : arb_add;
    assign tcdm_be_o   = held ? held_be   : arb_be;
    assign tcdm_data_o = held ? held_data : arb_data;
    assign tcdm_wen_o  = cur_is_load;

    assign gnt      = tcdm_req_o & tcdm_gnt_i;
    assign st_gnt_o = gnt & ~cur_is_load;

    always_comb begin
        ld_gnt_o = '0;
        for (int i = 0; i < NB_LD; i++) begin
            ld_gnt_o[i] = gnt & cur_is_load & (cur_ch == IW'(i));
        end
    end

    assign push         = gnt & (cur_is_load | (STORE_RESP != 0));
    assign pop          = tcdm_r_valid_i & cnt_nz;
    assign head_is_load = tag_is_load[rptr];
    assign head_ch      = tag_ch[rptr];

    always_comb begin
        ld_r_valid_o = '0;
        for (int i = 0; i < NB_LD; i++) begin
            ld_r_valid_o[i] = pop & head_is_load & (head_ch == IW'(i)) & ~rst_i;
        end
    end

    assign ld_r_data_o   = {NB_LD{tcdm_r_data_i}};
    assign outstanding_o = cnt;
    assign idle_o        = rst_i | (~cnt_nz & ~(|ld_req_i) & ~st_req_i & ~held);
    assign spurious_o    = spurious;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt          <= '0;
            wptr         <= '0;
            rptr         <= '0;
            rr_ptr       <= '0;
            grp_turn     <= TURN_LOAD;
            spurious     <= 1'b0;
            held         <= 1'b0;
            held_is_load <= 1'b0;
            held_contend <= 1'b0;
            held_ch      <= '0;
            held_add     <= '0;
            held_data    <= '0;
            held_be      <= '0;
        end else if (clear_i) begin
            cnt          <= '0;
            wptr         <= '0;
            rptr         <= '0;
            rr_ptr       <= '0;
            grp_turn     <= TURN_LOAD;
            spurious     <= 1'b0;
            held         <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);

            if (tcdm_r_valid_i && !cnt_nz) begin
                spurious <= 1'b1;
            end

            if (gnt && cur_is_load) begin
                rr_ptr <= (int'(cur_ch) == NB_LD - 1) ? '0 : cur_ch + IW'(1);
            end

            // Contention is judged when the winner was picked, so a request
            // that waited for its grant still flips the turn once granted.
            if (gnt && cur_contend) begin
                grp_turn <= (grp_turn == TURN_LOAD) ? TURN_STORE : TURN_LOAD;
            end

            if (gnt) begin
                held <= 1'b0;
            end else if (tcdm_req_o && !held) begin
                held         <= 1'b1;
                held_is_load <= arb_load;
                held_contend <= arb_contend;
                held_ch      <= rr_idx;
                held_add     <= arb_add;
                held_data    <= arb_data;
                held_be      <= arb_be;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_is_load[wptr] <= cur_is_load;
            tag_ch[wptr]      <= cur_ch;
        end
    end

`ifdef DATAMOVER_LDST_ARB_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_ld_stall_o <= '0;
            perf_st_stall_o <= '0;
            perf_full_o     <= '0;
        end else if (clear_i) begin
            perf_ld_stall_o <= '0;
            perf_st_stall_o <= '0;
            perf_full_o     <= '0;
        end else begin
            if ((|ld_req_i) && !(|ld_gnt_o)) begin
                perf_ld_stall_o <= perf_ld_stall_o + 32'd1;
            end
            if (st_req_i && !st_gnt_o) begin
                perf_st_stall_o <= perf_st_stall_o + 32'd1;
            end
            if (full) begin
                perf_full_o <= perf_full_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_datamover_tcdm_ldst_arbiter.sv
// tb/tb_datamover_tcdm_ldst_arbiter.sv - randomized scoreboard bench for datamover_tcdm_ldst_arbiter
module tb_datamover_tcdm_ldst_arbiter;

    localparam int NB_LD      = 2;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MAX_OUT    = 4;
    localparam int STORE_RESP = 1;
    localparam int BW         = DW / 8;
    localparam int CW         = $clog2(MAX_OUT) + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clr;
    logic [NB_LD-1:0]      ld_req;
    logic [NB_LD-1:0]      ld_gnt;
    logic [NB_LD*AW-1:0]   ld_add;
    logic [NB_LD*BW-1:0]   ld_be;
    logic [NB_LD*DW-1:0]   ld_r_data;
    logic [NB_LD-1:0]      ld_r_valid;
    logic                  st_req;
    logic                  st_gnt;
    logic [AW-1:0]         st_add;
    logic [DW-1:0]         st_data;
    logic [BW-1:0]         st_be;
    logic                  tcdm_req;
    logic                  tcdm_gnt;
    logic [AW-1:0]         tcdm_add;
    logic                  tcdm_wen;
    logic [BW-1:0]         tcdm_be;
    logic [DW-1:0]         tcdm_data;
    logic [DW-1:0]         tcdm_r_data;
    logic                  tcdm_r_valid;
    logic [CW-1:0]         outstanding;
    logic                  idle;
    logic                  spurious;
`ifdef DATAMOVER_LDST_ARB_PERF_EN
    logic [31:0]           perf_ld_stall;
    logic [31:0]           perf_st_stall;
    logic [31:0]           perf_full;
`endif

    always #5 clk = ~clk;

    datamover_tcdm_ldst_arbiter #(
        .NB_LD(NB_LD), .AW(AW), .DW(DW), .MAX_OUTSTANDING(MAX_OUT), .STORE_RESP(STORE_RESP)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .ld_req_i(ld_req), .ld_gnt_o(ld_gnt), .ld_add_i(ld_add), .ld_be_i(ld_be),
        .ld_r_data_o(ld_r_data), .ld_r_valid_o(ld_r_valid),
        .st_req_i(st_req), .st_gnt_o(st_gnt), .st_add_i(st_add), .st_data_i(st_data), .st_be_i(st_be),
        .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add), .tcdm_wen_o(tcdm_wen),
        .tcdm_be_o(tcdm_be), .tcdm_data_o(tcdm_data), .tcdm_r_data_i(tcdm_r_data),
        .tcdm_r_valid_i(tcdm_r_valid), .outstanding_o(outstanding), .idle_o(idle),
        .spurious_o(spurious)
`ifdef DATAMOVER_LDST_ARB_PERF_EN
        , .perf_ld_stall_o(perf_ld_stall), .perf_st_stall_o(perf_st_stall), .perf_full_o(perf_full)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct { bit is_load; int ch; } tag_t;
    typedef struct { int ch; logic [DW-1:0] data; } resp_t;

    tag_t  infl[$];     // transactions the target owes a response for, oldest first
    resp_t exp_q[$];    // load responses the DUT must present this cycle

    int   next_ch;      // first load channel to consider next
    bit   store_turn;   // on contention the store wins when set
    bit   m_spur;
    bit   m_held;
    bit   m_hload;
    int   m_hch;
    bit   m_hcont;
    bit   done_ld[NB_LD];
    bit   done_st;

    int p_req, p_gnt, p_rv, p_spur, p_clr, p_rst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic reset_model();
        infl.delete();
        next_ch    = 0;
        store_turn = 1'b0;
        m_spur     = 1'b0;
        m_held     = 1'b0;
    endtask

    task automatic drive();
        rst = ($urandom_range(999) < p_rst);
        clr = ($urandom_range(99) < p_clr);
        for (int i = 0; i < NB_LD; i++) begin
            if (done_ld[i]) begin
                ld_req[i]  = 1'b0;
                done_ld[i] = 1'b0;
            end
            if (!ld_req[i] && $urandom_range(99) < p_req) begin
                ld_req[i]            = 1'b1;
                ld_add[i*AW +: AW]   = $urandom;
                ld_be[i*BW +: BW]    = BW'($urandom);
            end
        end
        if (done_st) begin
            st_req  = 1'b0;
            done_st = 1'b0;
        end
        if (!st_req && $urandom_range(99) < p_req) begin
            st_req  = 1'b1;
            st_add  = $urandom;
            st_data = $urandom;
            st_be   = BW'($urandom);
        end
        tcdm_gnt = ($urandom_range(99) < p_gnt);
        if (rst)
            tcdm_r_valid = 1'b0;
        else if (infl.size() > 0)
            tcdm_r_valid = ($urandom_range(99) < p_rv);
        else
            tcdm_r_valid = ($urandom_range(99) < p_spur);
        tcdm_r_data = $urandom;
    endtask

    // Evaluated between edges with this cycle's inputs stable.
    task automatic step_model();
        int               cnt_now;
        bit               full;
        bit               have_w;
        bit               w_load;
        int               w_ch;
        bit               w_cont;
        int               pick;
        bit               st_ok;
        bit               exp_req;
        bit               exp_gnt;
        logic [NB_LD-1:0] exp_ld_gnt;
        tag_t             h;

        cnt_now = infl.size();
        if (rst) begin
            check("rst_req", tcdm_req, 0);
            check("rst_ld_gnt", ld_gnt, 0);
            check("rst_st_gnt", st_gnt, 0);
            check("rst_outstanding", outstanding, 0);
            check("rst_idle", idle, 1);
            check("rst_spurious", spurious, 0);
            reset_model();
            return;
        end

        full   = (cnt_now == MAX_OUT);
        have_w = 1'b0;
        w_load = 1'b0;
        w_ch   = 0;
        w_cont = 1'b0;
        if (m_held) begin
            have_w = 1'b1;
            w_load = m_hload;
            w_ch   = m_hch;
            w_cont = m_hcont;
        end else begin
            pick = -1;
            for (int k = 0; k < NB_LD; k++) begin
                if (pick < 0 && ld_req[(next_ch + k) % NB_LD] && !full)
                    pick = (next_ch + k) % NB_LD;
            end
            st_ok  = st_req && !(full && STORE_RESP != 0);
            w_cont = (pick >= 0) && st_ok;
            if (pick >= 0 && (!st_ok || !store_turn)) begin
                have_w = 1'b1;
                w_load = 1'b1;
                w_ch   = pick;
            end else if (st_ok) begin
                have_w = 1'b1;
            end
        end

        exp_req    = have_w && !clr;
        exp_gnt    = exp_req && tcdm_gnt;
        exp_ld_gnt = '0;
        if (exp_gnt && w_load) exp_ld_gnt[w_ch] = 1'b1;

        check("req", tcdm_req, exp_req);
        check("ld_gnt", ld_gnt, exp_ld_gnt);
        check("st_gnt", st_gnt, exp_gnt && !w_load);
        if (exp_req) begin
            check("wen", tcdm_wen, w_load);
            if (w_load) begin
                check("ld_add", tcdm_add, ld_add[w_ch*AW +: AW]);
                check("ld_be", tcdm_be, ld_be[w_ch*BW +: BW]);
            end else begin
                check("st_add", tcdm_add, st_add);
                check("st_be", tcdm_be, st_be);
                check("st_data", tcdm_data, st_data);
            end
        end
        check("outstanding", outstanding, cnt_now);
        check("spurious", spurious, m_spur);
        check("idle", idle, (cnt_now == 0) && (ld_req == 0) && !st_req && !m_held);

        if (tcdm_r_valid) begin
            if (cnt_now == 0) begin
                m_spur = 1'b1;
            end else begin
                h = infl.pop_front();
                if (h.is_load) exp_q.push_back('{h.ch, tcdm_r_data});
            end
        end

        if (clr) begin
            reset_model();
        end else if (exp_gnt) begin
            if (w_load || STORE_RESP != 0) infl.push_back('{w_load, w_ch});
            if (w_load) begin
                next_ch       = (w_ch + 1) % NB_LD;
                done_ld[w_ch] = 1'b1;
            end else begin
                done_st = 1'b1;
            end
            if (w_cont) store_turn = !store_turn;
            m_held = 1'b0;
        end else if (exp_req && !m_held) begin
            m_held  = 1'b1;
            m_hload = w_load;
            m_hch   = w_ch;
            m_hcont = w_cont;
        end
    endtask

    // Response monitor: runs late in each cycle, after the model has queued
    // what it expects the DUT to present.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (ld_r_valid != 0 || exp_q.size() != 0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_extra at %0t: got valid %0h expected none", $time, ld_r_valid);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", ld_r_valid, 64'(1) << e.ch);
                    check("rsp_data", ld_r_data, {NB_LD{e.data}});
                end
            end
        end
    end

    task automatic run_phase(input int cycles, input int req, input int g, input int rv,
                             input int sp, input int cl, input int rs);
        p_req  = req;
        p_gnt  = g;
        p_rv   = rv;
        p_spur = sp;
        p_clr  = cl;
        p_rst  = rs;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            drive();
            @(negedge clk);
            step_model();
        end
    endtask

    initial begin
        rst          = 1'b1;
        clr          = 1'b0;
        ld_req       = '0;
        ld_add       = '0;
        ld_be        = '0;
        st_req       = 1'b0;
        st_add       = '0;
        st_data      = '0;
        st_be        = '0;
        tcdm_gnt     = 1'b0;
        tcdm_r_valid = 1'b0;
        tcdm_r_data  = '0;
        done_st      = 1'b0;
        for (int i = 0; i < NB_LD; i++) done_ld[i] = 1'b0;
        reset_model();

        repeat (3) begin
            @(negedge clk);
            step_model();
        end

        //        cycles req gnt  rv spur clr rst(permille)
        run_phase(400,   90, 100, 100, 0,  0, 0);   // streaming, alternation
        run_phase(600,   60,  70,  60, 2,  0, 0);   // general traffic
        run_phase(200,   90, 100,   0, 0,  0, 0);   // responses withheld: fill to full
        run_phase(300,   80,  30,  40, 0,  0, 0);   // grants withheld: request hold
        run_phase(600,   50,  80,  50, 10, 3, 0);   // spurious responses and clears
        run_phase(600,   70,  80,  50, 3,  2, 6);   // resets with tags in flight
        run_phase(300,   70,  90,  70, 0,  0, 0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        clr = 1'b0;
        tcdm_r_valid = 1'b0;
        @(negedge clk);
        #5;
        check("rsp_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
